rs_station: RTL and testbench

- Parametrised successor to the fixed 6-entry split reservation station.
- One generic, depth/width/CDB-count parametrised station per execution unit; top level instantiates one for ALU, one for memory.
- Adds over previous generation: ready/valid handshakes on both sides, N-port CDB wakeup, same-cycle dispatch bypass, oldest-first issue, flush, and an occupancy count.

---
 rtl/rs_pkg.sv | 32 +++
 rtl/rs_age_select.sv | 31 +++
 rtl/rs_station.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rs_station.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared definitions for the reservation-station family.
//   - default parameter values for rs_station
//   - TAG_NONE: the ROB tag meaning "operand ready / no destination"
//   - 5-bit opcode encodings used by the dispatch front end
package rs_pkg;

  localparam int RS_ENTRIES = 4;
  localparam int RS_XLEN    = 32;
  localparam int RS_TAG_W   = 3;
  localparam int RS_OP_W    = 6;
  localparam int RS_CDB_N   = 2;

  localparam int TAG_NONE = 0;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_LW   = 5'd10;
  localparam logic [4:0] OP_SW   = 5'd11;
  localparam logic [4:0] OP_BEQ  = 5'd12;
  localparam logic [4:0] OP_BNE  = 5'd13;
  localparam logic [4:0] OP_BLT  = 5'd14;
  localparam logic [4:0] OP_BLTU = 5'd15;

endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: oldest-first picker over an age matrix (pure combinational).
//   eligible  in  ENTRIES          entries that may be picked
//   age       in  ENTRIES*ENTRIES  age[i][j]=1 means entry i is older than entry j
//   grant     out ENTRIES          one-hot: the oldest eligible entry
//   any_grant out 1                at least one entry is eligible
// Entry i wins when, for every other eligible j, it is older than j.
// The matrix is kept antisymmetric over valid entries by its owner, so at most
// one grant bit is set.
module rs_age_select
  import rs_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES
) (
  input  logic [ENTRIES-1:0]              eligible,
  input  logic [ENTRIES-1:0][ENTRIES-1:0] age,
  output logic [ENTRIES-1:0]              grant,
  output logic                            any_grant
);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_grant
      localparam logic [ENTRIES-1:0] SELF_BIT = ENTRIES'(1) << gi;
      // Non-eligible entries and the diagonal are don't-cares in the row test.
      assign grant[gi] = eligible[gi] & (&(age[gi] | ~eligible | SELF_BIT));
    end
  endgenerate

  assign any_grant = |eligible;

endmodule

// File: rtl/rs_station.sv
// rs_station: generic reservation station for one execution unit.
//   clk, rst (async, active low), flush (drop everything)
//   dispatch: in_valid/in_ready, in_op, in_v1/in_v2, in_q1/in_q2, in_imm, in_des
//   wakeup:   cdb_valid/cdb_tag/cdb_data, CDB_N broadcast ports
//   issue:    out_valid/out_ready, out_op, out_v1, out_v2, out_imm, out_des
//   status:   count (occupied slots), full
// Entries wait for their source tags on the CDB, then the oldest ready entry
// is moved into a registered output stage.
module rs_station
  import rs_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int XLEN    = RS_XLEN,
  parameter int TAG_W   = RS_TAG_W,
  parameter int OP_W    = RS_OP_W,
  parameter int CDB_N   = RS_CDB_N
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OP_W-1:0]                in_op,
  input  logic [XLEN-1:0]                in_v1,
  input  logic [XLEN-1:0]                in_v2,
  input  logic [TAG_W-1:0]               in_q1,
  input  logic [TAG_W-1:0]               in_q2,
  input  logic [XLEN-1:0]                in_imm,
  input  logic [TAG_W-1:0]               in_des,
  input  logic [CDB_N-1:0]               cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]         cdb_tag,
  input  logic [CDB_N*XLEN-1:0]          cdb_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OP_W-1:0]                out_op,
  output logic [XLEN-1:0]                out_v1,
  output logic [XLEN-1:0]                out_v2,
  output logic [XLEN-1:0]                out_imm,
  output logic [TAG_W-1:0]               out_des,
  output logic [$clog2(ENTRIES+1)-1:0]   count,
  output logic                           full
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES+1);
  localparam logic [TAG_W-1:0] TAG_0 = TAG_W'(TAG_NONE);

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } wake_t;

  // Tag lookup against all CDB ports; the lowest matching port wins because
  // the scan runs high-to-low and later hits overwrite earlier ones.
  function automatic wake_t cdb_match(input logic [TAG_W-1:0]       q,
                                      input logic [CDB_N-1:0]       vld,
                                      input logic [CDB_N*TAG_W-1:0] tags,
                                      input logic [CDB_N*XLEN-1:0]  data);
    wake_t r;
    r.hit  = 1'b0;
    r.data = '0;
    for (int p = CDB_N - 1; p >= 0; p--) begin
      if (vld[p] && (q != TAG_0) && (tags[p*TAG_W +: TAG_W] == q)) begin
        r.hit  = 1'b1;
        r.data = data[p*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  // Entry storage
  logic [ENTRIES-1:0]              valid_reg;
  logic [OP_W-1:0]                 op_reg  [ENTRIES];
  logic [XLEN-1:0]                 v1_reg  [ENTRIES];
  logic [XLEN-1:0]                 v2_reg  [ENTRIES];
  logic [XLEN-1:0]                 imm_reg [ENTRIES];
  logic [TAG_W-1:0]                q1_reg  [ENTRIES];
  logic [TAG_W-1:0]                q2_reg  [ENTRIES];
  logic [TAG_W-1:0]                des_reg [ENTRIES];
  logic [ENTRIES-1:0][ENTRIES-1:0] age_reg;
  logic [CNT_W-1:0]                count_reg;

  // Output stage
  logic             out_valid_reg;
  logic [OP_W-1:0]  out_op_reg;
  logic [XLEN-1:0]  out_v1_reg;
  logic [XLEN-1:0]  out_v2_reg;
  logic [XLEN-1:0]  out_imm_reg;
  logic [TAG_W-1:0] out_des_reg;

  wake_t              wake1 [ENTRIES];
  wake_t              wake2 [ENTRIES];
  wake_t              byp1;
  wake_t              byp2;
  logic [ENTRIES-1:0] eligible;
  logic [ENTRIES-1:0] grant;
  logic               any_grant;
  logic               load_en;
  logic               issue_fire;
  logic               dispatch_fire;
  logic               free_any;
  logic [IDX_W-1:0]   free_idx;
  logic               cdb_dup;

  logic [OP_W-1:0]    sel_op;
  logic [XLEN-1:0]    sel_v1;
  logic [XLEN-1:0]    sel_v2;
  logic [XLEN-1:0]    sel_imm;
  logic [TAG_W-1:0]   sel_des;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      // Eligibility is taken from registered tags only, so a CDB hit this
      // cycle makes the entry selectable on the following cycle.
      assign eligible[gi] = valid_reg[gi] && (q1_reg[gi] == TAG_0) && (q2_reg[gi] == TAG_0);
      assign wake1[gi]    = cdb_match(q1_reg[gi], cdb_valid, cdb_tag, cdb_data);
      assign wake2[gi]    = cdb_match(q2_reg[gi], cdb_valid, cdb_tag, cdb_data);
    end
  endgenerate

  assign byp1 = cdb_match(in_q1, cdb_valid, cdb_tag, cdb_data);
  assign byp2 = cdb_match(in_q2, cdb_valid, cdb_tag, cdb_data);

  rs_age_select #(.ENTRIES(ENTRIES)) u_select (
    .eligible  (eligible),
    .age       (age_reg),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // Lowest-index free slot, from registered valid bits: a slot vacated by
  // this cycle's issue is not visible here until the next cycle.
  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
    end
  end

  // One-hot grant mux
  always_comb begin
    sel_op  = '0;
    sel_v1  = '0;
    sel_v2  = '0;
    sel_imm = '0;
    sel_des = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) begin
        sel_op  = op_reg[i];
        sel_v1  = v1_reg[i];
        sel_v2  = v2_reg[i];
        sel_imm = imm_reg[i];
        sel_des = des_reg[i];
      end
    end
  end

  always_comb begin
    cdb_dup = 1'b0;
    for (int a = 0; a < CDB_N; a++) begin
      for (int b = a + 1; b < CDB_N; b++) begin
        if (cdb_valid[a] && cdb_valid[b] && (cdb_tag[a*TAG_W +: TAG_W] != TAG_0) &&
            (cdb_tag[a*TAG_W +: TAG_W] == cdb_tag[b*TAG_W +: TAG_W])) begin
          cdb_dup = 1'b1;
        end
      end
    end
  end

  assign full          = (count_reg == CNT_W'(ENTRIES));
  assign in_ready      = !full;
  assign count         = count_reg;
  assign load_en       = !out_valid_reg || out_ready;
  assign issue_fire    = any_grant && load_en;
  assign dispatch_fire = in_valid && !full && free_any && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      age_reg   <= '0;
      count_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_reg[i]  <= '0;
        v1_reg[i]  <= '0;
        v2_reg[i]  <= '0;
        imm_reg[i] <= '0;
        q1_reg[i]  <= '0;
        q2_reg[i]  <= '0;
        des_reg[i] <= '0;
      end
    end else if (flush) begin
      valid_reg <= '0;
      age_reg   <= '0;
      count_reg <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wake1[i].hit) begin
          q1_reg[i] <= TAG_0;
          v1_reg[i] <= wake1[i].data;
        end
        if (wake2[i].hit) begin
          q2_reg[i] <= TAG_0;
          v2_reg[i] <= wake2[i].data;
        end
        if (issue_fire && grant[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end
      if (dispatch_fire) begin
        valid_reg[free_idx] <= 1'b1;
        op_reg[free_idx]    <= in_op;
        imm_reg[free_idx]   <= in_imm;
        des_reg[free_idx]   <= in_des;
        q1_reg[free_idx]    <= byp1.hit ? TAG_0 : in_q1;
        v1_reg[free_idx]    <= byp1.hit ? byp1.data : in_v1;
        q2_reg[free_idx]    <= byp2.hit ? TAG_0 : in_q2;
        v2_reg[free_idx]    <= byp2.hit ? byp2.data : in_v2;
        // Newcomer is younger than everyone: set its column, clear its row
        // (the row write comes last so the diagonal ends up clear).
        for (int j = 0; j < ENTRIES; j++) begin
          age_reg[j][free_idx] <= 1'b1;
        end
        age_reg[free_idx] <= '0;
      end
      count_reg <= count_reg + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_op_reg    <= '0;
      out_v1_reg    <= '0;
      out_v2_reg    <= '0;
      out_imm_reg   <= '0;
      out_des_reg   <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      out_des_reg   <= '0;
    end else if (load_en) begin
      if (any_grant) begin
        out_valid_reg <= 1'b1;
        out_op_reg    <= sel_op;
        out_v1_reg    <= sel_v1;
        out_v2_reg    <= sel_v2;
        out_imm_reg   <= sel_imm;
        out_des_reg   <= sel_des;
      end else begin
        out_valid_reg <= 1'b0;
        out_des_reg   <= '0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_op    = out_op_reg;
  assign out_v1    = out_v1_reg;
  assign out_v2    = out_v2_reg;
  assign out_imm   = out_imm_reg;
  assign out_des   = out_des_reg;

  // Two CDB ports broadcasting the same live tag means the ROB handed out a
  // tag twice.
  a_cdb_unique: assert property (@(posedge clk) disable iff (!rst) !cdb_dup);

endmodule

// File: tb/tb_rs_station.sv
module tb_rs_station;
  import rs_pkg::*;

  localparam int ENTRIES = 4;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 3;
  localparam int OP_W    = 6;
  localparam int CDB_N   = 2;
  localparam int CNT_W   = $clog2(ENTRIES + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [OP_W-1:0]        in_op;
  logic [XLEN-1:0]        in_v1, in_v2, in_imm;
  logic [TAG_W-1:0]       in_q1, in_q2, in_des;
  logic [CDB_N-1:0]       cdb_valid;
  logic [TAG_W-1:0]       ctag  [CDB_N];
  logic [XLEN-1:0]        cdata [CDB_N];
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0]  cdb_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OP_W-1:0]        out_op;
  logic [XLEN-1:0]        out_v1, out_v2, out_imm;
  logic [TAG_W-1:0]       out_des;
  logic [CNT_W-1:0]       count;
  logic                   full;

  int checks   = 0;
  int failures = 0;
  bit verbose  = 1'b1;

  always #5 clk = ~clk;

  always_comb begin
    cdb_tag  = '0;
    cdb_data = '0;
    for (int p = 0; p < CDB_N; p++) begin
      cdb_tag[p*TAG_W +: TAG_W] = ctag[p];
      cdb_data[p*XLEN +: XLEN]  = cdata[p];
    end
  end

  rs_station #(
    .ENTRIES(ENTRIES), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .CDB_N(CDB_N)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
    .in_imm(in_imm), .in_des(in_des),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_v1(out_v1), .out_v2(out_v2), .out_imm(out_imm), .out_des(out_des),
    .count(count), .full(full)
  );

  // ---------------- reference model: age-ordered queue ----------------
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic [TAG_W-1:0] des;
  } ent_t;

  ent_t mq[$];      // index 0 is the oldest
  bit   m_ov;
  ent_t m_out;

  function automatic ent_t wake_ent(input ent_t e);
    ent_t r = e;
    bit h1 = 1'b0;
    bit h2 = 1'b0;
    for (int p = 0; p < CDB_N; p++) begin
      if (cdb_valid[p]) begin
        if (!h1 && e.q1 != 0 && ctag[p] == e.q1) begin r.q1 = '0; r.v1 = cdata[p]; h1 = 1'b1; end
        if (!h2 && e.q2 != 0 && ctag[p] == e.q2) begin r.q2 = '0; r.v2 = cdata[p]; h2 = 1'b1; end
      end
    end
    return r;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ov  = 1'b0;
    m_out = '0;
  endfunction

  // Advance the model over one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit   acc;
    int   sel;
    ent_t e;
    if (flush) begin
      mq.delete();
      m_ov      = 1'b0;
      m_out.des = '0;
      return;
    end
    acc = in_valid && (mq.size() < ENTRIES);
    if (!m_ov || out_ready) begin
      sel = -1;
      for (int k = 0; k < mq.size(); k++)
        if (sel < 0 && mq[k].q1 == 0 && mq[k].q2 == 0) sel = k;
      if (sel >= 0) begin
        m_ov  = 1'b1;
        m_out = mq[sel];
        mq.delete(sel);
      end else begin
        m_ov      = 1'b0;
        m_out.des = '0;
      end
    end
    for (int k = 0; k < mq.size(); k++) mq[k] = wake_ent(mq[k]);
    if (acc) begin
      e.op = in_op; e.v1 = in_v1; e.v2 = in_v2; e.imm = in_imm;
      e.q1 = in_q1; e.q2 = in_q2; e.des = in_des;
      mq.push_back(wake_ent(e));
    end
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void compare_model();
    check("model_out_valid", 64'(out_valid), 64'(m_ov));
    check("model_count", 64'(count), 64'(mq.size()));
    check("model_full", 64'(full), 64'(mq.size() == ENTRIES));
    check("model_in_ready", 64'(in_ready), 64'(mq.size() < ENTRIES));
    if (m_ov) begin
      check("model_out_op", 64'(out_op), 64'(m_out.op));
      check("model_out_v1", 64'(out_v1), 64'(m_out.v1));
      check("model_out_v2", 64'(out_v2), 64'(m_out.v2));
      check("model_out_imm", 64'(out_imm), 64'(m_out.imm));
      check("model_out_des", 64'(out_des), 64'(m_out.des));
    end else begin
      check("model_out_des_idle", 64'(out_des), 64'(0));
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
    if (verbose)
      $display("cyc t=%0t in_valid=%0b out_valid=%0b out_des=%0d out_v1=%h count=%0d full=%0b",
               $time, in_valid, out_valid, out_des, out_v1, count, full);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_v1 = '0; in_v2 = '0; in_imm = '0; in_q1 = '0; in_q2 = '0; in_des = '0;
    cdb_valid = '0;
    for (int p = 0; p < CDB_N; p++) begin ctag[p] = '0; cdata[p] = '0; end
  endtask

  task automatic drive_ready(input int des, input int v1);
    in_valid = 1'b1; in_op = OP_W'(OP_ADD);
    in_v1 = XLEN'(v1); in_v2 = XLEN'(v1 + 1); in_imm = '0;
    in_q1 = '0; in_q2 = '0; in_des = TAG_W'(des);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int iv, op, v1, v2, q1, q2, imm, des;
    int cv, t0, d0, t1, d1;
    int e_ov, e_v1, e_v2, e_des, e_cnt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1, int'(OP_ADD), 5, 7, 0, 0, 0, 3,    0, 0, 0, 0, 0,        0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,        1, 5, 7, 3, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,        0, 0, 0, 0, 0};
    tbl[3]  = '{1, int'(OP_SUB), 'h11, 1, 2, 0, 0, 5, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,               2, 0, 0, 2, 'hDEAD,   0, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,        1, 'hDEAD, 1, 5, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,        0, 0, 0, 0, 0};
    tbl[7]  = '{1, int'(OP_LW), 3, 'h22, 0, 4, 8, 6,  1, 4, 9, 0, 0,        0, 0, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,        1, 3, 9, 6, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,        0, 0, 0, 0, 0};
    tbl[10] = '{1, int'(OP_BEQ), 'h33, 10, 1, 0, 0, 2, 0, 0, 0, 0, 0,       0, 0, 0, 0, 1};
    tbl[11] = '{1, int'(OP_AND), 20, 21, 0, 0, 0, 4,  0, 0, 0, 0, 0,        0, 0, 0, 0, 2};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0,               1, 1, 'h77, 0, 0,     1, 20, 21, 4, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,        1, 'h77, 10, 2, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0,        0, 0, 0, 0, 0};

    // ---- reset state ----
    rst = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    model_reset();
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_op", 64'(out_op), 64'(0));
    check("rst_out_v1", 64'(out_v1), 64'(0));
    check("rst_out_v2", 64'(out_v2), 64'(0));
    check("rst_out_imm", 64'(out_imm), 64'(0));
    check("rst_out_des", 64'(out_des), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_full", 64'(full), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b1;

    // ---- table: latency, wakeup, bypass, age among eligible ----
    for (int i = 0; i < 15; i++) begin
      in_valid = (tbl[i].iv != 0);
      in_op = OP_W'(tbl[i].op);
      in_v1 = XLEN'(tbl[i].v1); in_v2 = XLEN'(tbl[i].v2); in_imm = XLEN'(tbl[i].imm);
      in_q1 = TAG_W'(tbl[i].q1); in_q2 = TAG_W'(tbl[i].q2); in_des = TAG_W'(tbl[i].des);
      cdb_valid = CDB_N'(tbl[i].cv);
      ctag[0] = TAG_W'(tbl[i].t0); cdata[0] = XLEN'(tbl[i].d0);
      ctag[1] = TAG_W'(tbl[i].t1); cdata[1] = XLEN'(tbl[i].d1);
      step();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("vec%0d_out_des", i), 64'(out_des), 64'(tbl[i].e_des));
      check($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      if (tbl[i].e_ov != 0) begin
        check($sformatf("vec%0d_out_v1", i), 64'(out_v1), 64'(tbl[i].e_v1));
        check($sformatf("vec%0d_out_v2", i), 64'(out_v2), 64'(tbl[i].e_v2));
      end
    end
    idle_inputs();

    // ---- fill with output stalled, then drain in dispatch order ----
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive_ready(k, 'h100 + k);
      step();
      if (k >= 2) begin
        check("fill_hold_des", 64'(out_des), 64'(1));
        check("fill_hold_v1", 64'(out_v1), 64'('h101));
      end
    end
    check("fill_full", 64'(full), 64'(1));
    check("fill_in_ready", 64'(in_ready), 64'(0));
    check("fill_count", 64'(count), 64'(ENTRIES));
    idle_inputs();
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      check("drain_valid", 64'(out_valid), 64'(1));
      check("drain_order_des", 64'(out_des), 64'(k));
    end
    step();
    check("drain_empty_valid", 64'(out_valid), 64'(0));
    check("drain_empty_count", 64'(count), 64'(0));

    // ---- flush with 3 entries held plus a stalled output ----
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive_ready(k, 'h200 + k);
      step();
    end
    check("preflush_count", 64'(count), 64'(3));
    check("preflush_valid", 64'(out_valid), 64'(1));
    drive_ready(7, 'h300);
    flush = 1'b1;
    cdb_valid[0] = 1'b1; ctag[0] = 3'd5; cdata[0] = 32'h55;
    step();
    check("flush_count", 64'(count), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    idle_inputs();
    out_ready = 1'b1;
    step();
    check("flush_dropped_valid", 64'(out_valid), 64'(0));
    check("flush_dropped_count", 64'(count), 64'(0));

    // ---- asynchronous reset mid-operation ----
    out_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      drive_ready(k, 'h400 + k);
      step();
    end
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_des", 64'(out_des), 64'(0));
    check("arst_out_v1", 64'(out_v1), 64'(0));
    check("arst_count", 64'(count), 64'(0));
    check("arst_full", 64'(full), 64'(0));
    model_reset();
    #1;
    rst = 1'b1;

    // ---- randomized traffic against the queue model ----
    verbose = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      flush    = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 9) < 6);
      in_op    = OP_W'($urandom_range(0, 15));
      in_v1    = $urandom();
      in_v2    = $urandom();
      in_imm   = $urandom();
      in_q1    = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, 7));
      in_q2    = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, 7));
      in_des   = TAG_W'($urandom_range(0, 7));
      for (int p = 0; p < CDB_N; p++) begin
        cdb_valid[p] = ($urandom_range(0, 2) != 0);
        ctag[p]      = TAG_W'($urandom_range(0, 7));
        cdata[p]     = $urandom();
      end
      for (int b = 1; b < CDB_N; b++)
        for (int a = 0; a < b; a++)
          if (cdb_valid[a] && cdb_valid[b] && ctag[a] != 0 && ctag[a] == ctag[b])
            cdb_valid[b] = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
